// File: rtl/stopwatch_btn_cmd.sv
// Purpose : turns the raw start/pause and stop buttons into debounced levels and single-cycle press pulses.
// Latency : a pulse and level rise follow SYNC_STAGES+DEBOUNCE_CNT-1 edges after the first sampled stable high.
// Backpr. : none; pulses are fire-and-forget and the consumer must accept one whenever it appears.
// Ports   : clk, rst (async, active high); i_btn_start_pause, i_btn_stop raw buttons, asynchronous to clk;
//           o_start_pause, o_stop registered one-cycle pulses; o_btn_level[0]=start/pause, [1]=stop, registered.
module stopwatch_btn_cmd #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_start_pause,
    input  logic       i_btn_stop,
    output logic       o_start_pause,
    output logic       o_stop,
    output logic [1:0] o_btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Channel 0 is start/pause, channel 1 is stop.
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    state_t                 state  [2];
    logic [CW-1:0]          cnt    [2];
    logic [1:0]             s;
    logic [1:0]             fire;

    assign raw = {i_btn_stop, i_btn_start_pause};

    // fire marks the edge on which a channel completes a debounced press.
    always_comb begin
        s    = '0;
        fire = '0;
        for (int i = 0; i < 2; i++) begin
            s[i]    = sync_q[i][SYNC_STAGES-1];
            fire[i] = (state[i] == PRESS_WAIT) && s[i] && (cnt[i] == CNT_MAX - CNT_ONE);
        end
    end

    // Reset parks each channel in RELEASE_WAIT: a button already held when
    // reset drops must be seen released for a full window before it can
    // produce a press, so no spurious command comes out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '0;
                state[i]  <= RELEASE_WAIT;
                cnt[i]    <= '0;
            end
            o_start_pause <= 1'b0;
            o_stop        <= 1'b0;
            o_btn_level   <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                case (state[i])
                    IDLE: begin
                        o_btn_level[i] <= 1'b0;
                        if (s[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end else begin
                            cnt[i]   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s[i]) begin
                            state[i]       <= IDLE;
                            cnt[i]         <= '0;
                            o_btn_level[i] <= 1'b0;
                        end else if (fire[i]) begin
                            state[i]       <= HELD;
                            cnt[i]         <= CNT_MAX;
                            o_btn_level[i] <= 1'b1;
                        end else begin
                            cnt[i]         <= (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_ONE;
                            o_btn_level[i] <= 1'b0;
                        end
                    end
                    HELD: begin
                        o_btn_level[i] <= 1'b1;
                        if (!s[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s[i]) begin
                            // Release bounce: fall back to HELD without a new pulse.
                            state[i]       <= HELD;
                            o_btn_level[i] <= 1'b1;
                        end else if (cnt[i] == CNT_MAX - CNT_ONE) begin
                            state[i]       <= IDLE;
                            cnt[i]         <= '0;
                            o_btn_level[i] <= 1'b0;
                        end else begin
                            cnt[i]         <= (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_ONE;
                            o_btn_level[i] <= 1'b1;
                        end
                    end
                    default: begin
                        state[i]       <= IDLE;
                        cnt[i]         <= '0;
                        o_btn_level[i] <= 1'b0;
                    end
                endcase
            end
            // Stop wins a same-edge tie; the start/pause press is swallowed
            // (its channel still moves to HELD, so it never fires later).
            o_stop        <= fire[1];
            o_start_pause <= fire[0] & ~fire[1];
        end
    end

endmodule

// File: tb/tb_stopwatch_btn_cmd.sv
// Testbench for stopwatch_btn_cmd: directed scenarios followed by random button
// activity, every cycle compared against a sample-window model of the debouncer.
module tb_stopwatch_btn_cmd;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       bsp;
    logic       bstop;
    logic       o_sp;
    logic       o_stop;
    logic [1:0] o_lvl;

    always #5 clk = ~clk;

    stopwatch_btn_cmd #(
        .SYNC_STAGES  (SYNC),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_btn_start_pause (bsp),
        .i_btn_stop        (bstop),
        .o_start_pause     (o_sp),
        .o_stop            (o_stop),
        .o_btn_level       (o_lvl)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw-sample history and the history of what the
    // debouncer sees (raw delayed SYNC edges, zeros right after reset).
    // A level flips when the last DEB seen samples all disagree with it.
    bit [63:0] rawh [2];
    bit [63:0] sh   [2];
    int        nraw [2];
    int        nsh  [2];
    bit [1:0]  lvl;
    bit        exp_sp;
    bit        exp_stop;

    int cyc = 0;
    int sp_cnt = 0;
    int stop_cnt = 0;
    int last_sp_cyc = -1;
    int lvl0_rise_cyc = -1;
    bit prev_lvl0 = 1'b1;
    bit lvl0_dropped;
    int k0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            rawh[c] = '0;
            sh[c]   = '0;
            nraw[c] = 0;
            nsh[c]  = 0;
        end
        lvl      = 2'b11;
        exp_sp   = 1'b0;
        exp_stop = 1'b0;
    endtask

    task automatic model_edge();
        bit rise [2];
        for (int c = 0; c < 2; c++) begin
            bit s;
            bit r;
            r = (c == 0) ? bsp : bstop;
            s = (nraw[c] >= SYNC) ? rawh[c][SYNC-1] : 1'b0;
            rawh[c] = {rawh[c][62:0], r};
            nraw[c]++;
            sh[c] = {sh[c][62:0], s};
            nsh[c]++;
            rise[c] = 1'b0;
            if (nsh[c] >= DEB && sh[c][DEB-1:0] == {DEB{!lvl[c]}}) begin
                rise[c] = !lvl[c];
                lvl[c]  = !lvl[c];
            end
        end
        exp_stop = rise[1];
        exp_sp   = rise[0] && !rise[1];
    endtask

    // One clock: update the model on the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        cyc++;
        @(negedge clk);
        check("pulse_start_pause", 32'(o_sp), 32'(exp_sp));
        check("pulse_stop", 32'(o_stop), 32'(exp_stop));
        check("btn_level", 32'(o_lvl), 32'(lvl));
        check("pulses_exclusive", 32'(o_sp & o_stop), 32'd0);
        if (o_sp)   begin sp_cnt++; last_sp_cyc = cyc; end
        if (o_stop) stop_cnt++;
        if (o_lvl[0] && !prev_lvl0) lvl0_rise_cyc = cyc;
        if (!o_lvl[0]) lvl0_dropped = 1'b1;
        prev_lvl0 = o_lvl[0];
    endtask

    // Short reset pulse between clock edges; outputs must react before any edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_sp"}, 32'(o_sp), 32'd0);
        check({tag, "_stop"}, 32'(o_stop), 32'd0);
        check({tag, "_level"}, 32'(o_lvl), 32'd3);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        bit got;
        rst   = 1'b1;
        bsp   = 1'b1;
        bstop = 1'b0;
        model_reset();

        // Button held before, through and after reset release.
        repeat (3) step();
        rst = 1'b0;
        sp_cnt = 0;
        repeat (20) step();
        check("s1_no_pulse", 32'(sp_cnt), 32'd0);
        check("s1_level_held", 32'(o_lvl[0]), 32'd1);
        bsp = 1'b0;
        repeat (10) step();
        bsp = 1'b1;
        repeat (10) step();
        check("s1_repress_pulse", 32'(sp_cnt), 32'd1);

        // Clean press with exact latency.
        bsp = 1'b0;
        repeat (10) step();
        sp_cnt = 0;
        bsp = 1'b1;
        k0 = cyc + 1;
        repeat (20) step();
        check("s2_pulse_count", 32'(sp_cnt), 32'd1);
        check("s2_pulse_edge", 32'(last_sp_cyc - k0), 32'd5);
        check("s2_level_edge", 32'(lvl0_rise_cyc - k0), 32'd5);

        // Bouncing press: 2-cycle toggles, then a stable high.
        bsp = 1'b0;
        repeat (10) step();
        sp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            bsp = ~i[0];
            repeat (2) step();
        end
        bsp = 1'b1;
        k0 = cyc + 1;
        repeat (20) step();
        check("s3_pulse_count", 32'(sp_cnt), 32'd1);
        check("s3_pulse_edge", 32'(last_sp_cyc - k0), 32'd5);

        // Short release glitch while held.
        sp_cnt = 0;
        lvl0_dropped = 1'b0;
        bsp = 1'b0;
        repeat (3) step();
        bsp = 1'b1;
        repeat (10) step();
        check("s4_no_second_pulse", 32'(sp_cnt), 32'd0);
        check("s4_level_kept", 32'(lvl0_dropped), 32'd0);
        bsp = 1'b0;
        repeat (12) step();
        check("s4_level_cleared", 32'(o_lvl[0]), 32'd0);

        // Both buttons rise together.
        sp_cnt = 0;
        stop_cnt = 0;
        bsp = 1'b1;
        bstop = 1'b1;
        repeat (20) step();
        check("s5_stop_count", 32'(stop_cnt), 32'd1);
        check("s5_sp_suppressed", 32'(sp_cnt), 32'd0);
        bsp = 1'b0;
        bstop = 1'b0;
        repeat (12) step();
        bsp = 1'b1;
        repeat (12) step();
        check("s5_sp_alone", 32'(sp_cnt), 32'd1);
        bsp = 1'b0;
        repeat (12) step();

        // Reset in the middle of a press (counter at 2), button kept held.
        sp_cnt = 0;
        bsp = 1'b1;
        repeat (4) step();
        async_reset("s6_rst");
        repeat (20) step();
        check("s6_no_pulse_after_rst", 32'(sp_cnt), 32'd0);
        bsp = 1'b0;
        repeat (8) step();
        bsp = 1'b1;
        repeat (12) step();
        check("s6_pulse_after_release", 32'(sp_cnt), 32'd1);

        // Pulse in flight is cleared by reset without a clock edge.
        bsp = 1'b0;
        repeat (12) step();
        bsp = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = o_sp;
        end
        check("s7_pulse_seen", 32'(got), 32'd1);
        async_reset("s7_rst");
        repeat (4) step();

        // Random button activity with occasional resets.
        for (int b = 0; b < 80; b++) begin
            bsp   = 1'($urandom_range(0, 1));
            bstop = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) step();
            if ($urandom_range(0, 19) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_btn_cmd.md
# stopwatch_btn_cmd

Converts the two raw stopwatch push buttons (start/pause, stop) into clean, single-cycle command pulses for the stopwatch controller. Each button passes through a synchronizer, a debounce counter and a per-button press/release state machine. The block sits between the board pins and the stopwatch control FSM, and is the producing end of its `i_start_pause` / `i_stop` pulse inputs.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops per button. Legal values are 2 or more.
- `DEBOUNCE_CNT`, default 500000: number of consecutive equal synchronized samples needed to accept a level change (10 ms at 50 MHz). Legal values satisfy `DEBOUNCE_CNT >= SYNC_STAGES+1`.
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: asynchronous, active-high reset. One clock domain only.
- `i_btn_start_pause`  in  1: raw start/pause button, active high, asynchronous to `clk`.
- `i_btn_stop`  in  1: raw stop button, active high, asynchronous to `clk`.
- `o_start_pause`  out  1: one-cycle command pulse, registered.
- `o_stop`  out  1: one-cycle command pulse, registered.
- `o_btn_level`  out  2: debounced button levels; bit0 is start/pause, bit1 is stop. Registered.

## Operation
- Each button has its own synchronizer. The synchronizer output `s` feeds one FSM and one counter, `cnt`.
- `cnt` width is `$clog2(DEBOUNCE_CNT+1)`. It saturates and never wraps.
- FSM states are IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
- IDLE:
  - `s=1` goes to PRESS_WAIT with `cnt=1`.
  - Otherwise stay, with `cnt=0`.
- PRESS_WAIT:
  - `s=0` returns to IDLE with `cnt=0`.
  - `s=1` increments `cnt`. When `cnt` reaches `DEBOUNCE_CNT`, go to HELD and fire the pulse.
- HELD:
  - `s=0` goes to RELEASE_WAIT with `cnt=1`.
  - Otherwise stay.
- RELEASE_WAIT:
  - `s=1` returns to HELD. No pulse is generated.
  - `s=0` increments `cnt`. At `DEBOUNCE_CNT`, go to IDLE.
- Pulses fire only on a debounced press. A release never generates a pulse.
- `o_btn_level[i]` is 1 when channel i is in HELD or RELEASE_WAIT.
- Reset state of each channel is RELEASE_WAIT with `cnt=0`. Synchronizer flops reset to 0.
  - A button held through reset release therefore gives no pulse. The channel must first see `DEBOUNCE_CNT` consecutive lows.
  - This is guaranteed by `DEBOUNCE_CNT >= SYNC_STAGES+1`.
- Simultaneous events: if both channels enter HELD on the same edge, only `o_stop` pulses. The start/pause press is consumed: the channel still enters HELD and no later pulse is emitted for it.
- `o_start_pause` and `o_stop` are never high in the same cycle.

## Timing
- Reset values while `rst=1`: `o_start_pause=0`, `o_stop=0`, `o_btn_level=2'b11` (both channels in RELEASE_WAIT). All counters and synchronizers are 0.
- Reset assertion takes effect immediately, without waiting for a clock edge.
- Press latency: let edge k0 be the first edge that samples a stable raw high.
  - `s` is first seen high at edge k0+SYNC_STAGES.
  - The pulse is high for exactly the one cycle after edge k0+SYNC_STAGES+DEBOUNCE_CNT-1.
  - `o_btn_level` rises at that same edge.
- Release latency: `o_btn_level` falls at edge k1+SYNC_STAGES+DEBOUNCE_CNT-1, where k1 is the first edge sampling a stable raw low.
- Any interruption of `s` during PRESS_WAIT or RELEASE_WAIT restarts the full `DEBOUNCE_CNT` window.
- A new pulse requires passing through IDLE: a full debounced release, then a full debounced press.
- Reset mid-operation (any state, any `cnt`) abandons any pending pulse. A pulse in flight is cleared asynchronously.

## Test plan
All scenarios use `SYNC_STAGES=2`, `DEBOUNCE_CNT=4`.
- **Reset, button held:** hold `i_btn_start_pause=1` before, through and 20 cycles after `rst` deassertion.
  - Required: no pulse, `o_btn_level=2'b11` throughout reset, and `o_btn_level[0]` stays 1 afterwards.
  - Then release for 10 cycles and press again: one `o_start_pause` pulse.
- **Clean press:** after an idle period, `i_btn_start_pause` rises before edge k0 and is held 20 cycles.
  - Required: `o_start_pause=1` only between edges k0+5 and k0+6.
  - `o_btn_level[0]` rises at edge k0+5.
  - Exactly one pulse.
- **Bouncing press:** raw input toggles every 2 cycles for 12 cycles, then is held high.
  - Required: exactly one pulse, 5 edges after the first sample of the final stable high.
- **Release glitch:** while in HELD, drive raw low for 3 cycles, then high again.
  - Required: no second pulse, and `o_btn_level[0]` stays 1.
  - Afterwards, a low held for 10 or more cycles clears `o_btn_level[0]`.
- **Simultaneous press:** both raw buttons rise in the same cycle.
  - Required: one `o_stop` pulse and `o_start_pause=0` throughout.
  - After both are released and start/pause is pressed alone: one `o_start_pause` pulse.
- **Reset mid-press:** assert `rst` for a half cycle while start/pause is in PRESS_WAIT with `cnt=2`, keeping the button held.
  - Required: outputs go to their reset values immediately.
  - No pulse follows until the button is released for 4 or more synchronized cycles and pressed again.
